// File: rtl/detector_secuencia_pkg.sv
// Shared constants and the KMP next-state function for the serial pattern matchers.
package detector_secuencia_pkg;

  localparam int MAX_LEN     = 8;
  localparam int MAX_SW      = $clog2(MAX_LEN + 1);
  localparam int IDX_W       = $clog2(MAX_LEN);
  localparam int SEQ_LEN_DEF = 4;
  localparam int STATE_W     = $clog2(SEQ_LEN_DEF + 1);

  localparam logic [SEQ_LEN_DEF-1:0] SEQ1_DEF = 4'b1011;
  localparam logic [SEQ_LEN_DEF-1:0] SEQ2_DEF = 4'b0110;

  // Longest pattern prefix that is a suffix of (prefix of length st, then b).
  // The pattern is right-aligned in pat; its first received bit is pat[len-1].
  function automatic logic [MAX_SW-1:0] kmp_next(
    input logic [MAX_LEN-1:0] pat,
    input int                 len,
    input logic [MAX_SW-1:0]  st,
    input logic               b
  );
    logic [MAX_SW-1:0] best;
    logic              ok;
    logic              s_bit;
    int                idx;
    best = '0;
    for (int k = 1; k <= MAX_LEN; k++) begin
      if (k <= len && k <= int'(st) + 1) begin
        ok = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
          if (i < k) begin
            idx   = int'(st) + 1 - k + i;
            s_bit = (idx == int'(st)) ? b : pat[IDX_W'(len - 1 - idx)];
            if (s_bit != pat[IDX_W'(len - 1 - i)]) ok = 1'b0;
          end
        end
        if (ok) best = MAX_SW'(k);
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/detector_secuencia_seq_matcher.sv
// Overlapping serial pattern matcher; hit is registered and high while the FSM sits in the
// full-match state, so it pulses on the edge that samples the last pattern bit.
module seq_matcher
  import detector_secuencia_pkg::*;
#(
  parameter int                   SEQ_LEN = SEQ_LEN_DEF,
  parameter logic [SEQ_LEN-1:0]   PATTERN = SEQ1_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_in,
  output logic hit
);

  localparam int SW = $clog2(SEQ_LEN + 1);

  logic [SW-1:0]     state;
  logic [MAX_SW-1:0] nxt;

  assign nxt = kmp_next(MAX_LEN'(PATTERN), SEQ_LEN, MAX_SW'(state), bit_in);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= '0;
      hit   <= 1'b0;
    end else begin
      state <= SW'(nxt);
      hit   <= (nxt == MAX_SW'(SEQ_LEN));
    end
  end

endmodule

// File: rtl/detector_secuencia.sv
// Two independent overlapping serial pattern detectors driving one LED each.
// Optional saturating hit counters when DETECTOR_HIT_COUNT_EN is defined.
module detector_secuencia
  import detector_secuencia_pkg::*;
#(
  parameter int                 SEQ_LEN = SEQ_LEN_DEF,
  parameter logic [SEQ_LEN-1:0] SEQ1    = SEQ1_DEF,
  parameter logic [SEQ_LEN-1:0] SEQ2    = SEQ2_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entrada,
  output logic       led1,
  output logic       led2
`ifdef DETECTOR_HIT_COUNT_EN
  ,
  output logic [7:0] count1,
  output logic [7:0] count2
`endif
);

  seq_matcher #(.SEQ_LEN(SEQ_LEN), .PATTERN(SEQ1)) u_match1 (
    .clk(clk), .reset(reset), .bit_in(entrada), .hit(led1)
  );

  seq_matcher #(.SEQ_LEN(SEQ_LEN), .PATTERN(SEQ2)) u_match2 (
    .clk(clk), .reset(reset), .bit_in(entrada), .hit(led2)
  );

`ifdef DETECTOR_HIT_COUNT_EN
  // The registered count lags the LED by one edge; adding the live LED makes the
  // visible count step on the same edge the matcher enters its full-match state.
  logic [7:0] cnt1_q;
  logic [7:0] cnt2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt1_q <= 8'h00;
      cnt2_q <= 8'h00;
    end else begin
      if (led1 && cnt1_q != 8'hFF) cnt1_q <= cnt1_q + 8'h01;
      if (led2 && cnt2_q != 8'hFF) cnt2_q <= cnt2_q + 8'h01;
    end
  end

  assign count1 = (cnt1_q == 8'hFF) ? 8'hFF : cnt1_q + {7'b0, led1};
  assign count2 = (cnt2_q == 8'hFF) ? 8'hFF : cnt2_q + {7'b0, led2};
`endif

endmodule

// File: tb/tb_detector_secuencia.sv
// Bench for detector_secuencia: directed vector table, async-reset corner cases, random vs model.
module tb_detector_secuencia;
  import detector_secuencia_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic entrada = 1'b0;
  logic led1, led2;
`ifdef DETECTOR_HIT_COUNT_EN
  logic [7:0] count1, count2;
`endif

  detector_secuencia dut (
    .clk(clk), .reset(reset), .entrada(entrada), .led1(led1), .led2(led2)
`ifdef DETECTOR_HIT_COUNT_EN
    , .count1(count1), .count2(count2)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic rst;
    logic b;
    logic e1;
    logic e2;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic b, input logic e1, input logic e2);
    vec_t v;
    v.rst = r; v.b = b; v.e1 = e1; v.e2 = e2;
    vecs.push_back(v);
  endfunction

  task automatic step(input logic b);
    entrada = b;
    @(posedge clk);
    #1;
  endtask

  // Reference: keep the received history and compare its tail against the patterns.
  logic [7:0] hist;
  int         nbits;
  int         hits1, hits2;
  logic       exp1, exp2;

  initial begin
    // Reset held with toggling input
    add(0, 1, 0, 0); add(0, 0, 0, 0); add(0, 1, 0, 0);
    // 1011 then a trailing 0 (pulse ends, 0110 overlaps)
    add(1, 1, 0, 0); add(1, 0, 0, 0); add(1, 1, 0, 0); add(1, 1, 1, 0);
    add(1, 0, 0, 1);
    add(0, 0, 0, 0);
    // 1011011
    add(1, 1, 0, 0); add(1, 0, 0, 0); add(1, 1, 0, 0); add(1, 1, 1, 0);
    add(1, 0, 0, 1); add(1, 1, 0, 0); add(1, 1, 1, 0);
    add(0, 0, 0, 0);
    // 0110110
    add(1, 0, 0, 0); add(1, 1, 0, 0); add(1, 1, 0, 0); add(1, 0, 0, 1);
    add(1, 1, 0, 0); add(1, 1, 1, 0); add(1, 0, 0, 1);

    reset = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst;
      step(vecs[i].b);
      check($sformatf("vec%0d_led1", i), 8'(led1), 8'(vecs[i].e1));
      check($sformatf("vec%0d_led2", i), 8'(led2), 8'(vecs[i].e2));
`ifdef DETECTOR_HIT_COUNT_EN
      if (!vecs[i].rst) begin
        check("rst_count1", count1, 8'h00);
        check("rst_count2", count2, 8'h00);
      end
`endif
    end

    // Async reset mid-cycle clears a lit LED immediately
    reset = 1'b0; step(0); reset = 1'b1;
    step(1); step(0); step(1); step(1);
    check("pre_reset_led1", 8'(led1), 8'h01);
    #3 reset = 1'b0;
    #1 check("async_clear_led1", 8'(led1), 8'h00);
    #2 reset = 1'b1;

    // Partial 101 discarded by a mid-cycle reset pulse, so the next 1 is no hit
    step(0); reset = 1'b0; step(0); reset = 1'b1;
    step(1); step(0); step(1);
    #3 reset = 1'b0;
    #1 check("mid_reset_led1", 8'(led1), 8'h00);
    #2 reset = 1'b1;
    step(1);
    check("after_reset_led1", 8'(led1), 8'h00);
    check("after_reset_led2", 8'(led2), 8'h00);

    // Random stream against the history model
    reset = 1'b0; step(0); reset = 1'b1;
    hist = '0; nbits = 0; hits1 = 0; hits2 = 0;
    for (int i = 0; i < 256; i++) begin
      logic b;
      b = 1'($urandom % 2);
      step(b);
      hist  = {hist[6:0], b};
      nbits++;
      exp1 = (nbits >= SEQ_LEN_DEF) && (hist[SEQ_LEN_DEF-1:0] == SEQ1_DEF);
      exp2 = (nbits >= SEQ_LEN_DEF) && (hist[SEQ_LEN_DEF-1:0] == SEQ2_DEF);
      if (exp1) hits1++;
      if (exp2) hits2++;
      check($sformatf("rnd%0d_led1", i), 8'(led1), 8'(exp1));
      check($sformatf("rnd%0d_led2", i), 8'(led2), 8'(exp2));
`ifdef DETECTOR_HIT_COUNT_EN
      check($sformatf("rnd%0d_count1", i), count1, 8'((hits1 > 255) ? 255 : hits1));
      check($sformatf("rnd%0d_count2", i), count2, 8'((hits2 > 255) ? 255 : hits2));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
